// File: rtl/alu_issue_ctrl_if.sv
// Issue-side and writeback-side handshake/bus signals of the ALU issue controller,
// plus the operand/result wires to the combinational ALU.
interface alu_issue_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;

  logic [XLEN-1:0] alu_op_a;
  logic [XLEN-1:0] alu_op_b;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_result;
  logic            out_wb_en;
  logic            out_branch;
  logic            out_taken;
  logic            out_illegal;

  // Environment side: register read, the ALU itself and writeback.
  modport master (
    output in_valid, in_instr, in_rs1_val, in_rs2_val,
    output alu_result, alu_zero,
    output out_ready,
    input  in_ready,
    input  alu_op_a, alu_op_b, alu_ctrl,
    input  out_valid, out_rd, out_result, out_wb_en, out_branch, out_taken, out_illegal
  );

  // Issue controller side.
  modport slave (
    input  in_valid, in_instr, in_rs1_val, in_rs2_val,
    input  alu_result, alu_zero,
    input  out_ready,
    output in_ready,
    output alu_op_a, alu_op_b, alu_ctrl,
    output out_valid, out_rd, out_result, out_wb_en, out_branch, out_taken, out_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// RV32I ALU/branch issue controller: decode into a registered issue stage (S1) that
// drives the external ALU, then capture the ALU result into a writeback record (S2).
module alu_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLL  = 3'b101,
    ALU_SRL  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_R = 7'b0110011,
    OP_I = 7'b0010011,
    OP_B = 7'b1100011
  } opcode_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode        = bus.in_instr[6:0];
  assign funct3        = bus.in_instr[14:12];
  assign funct7        = bus.in_instr[31:25];
  assign rd            = bus.in_instr[11:7];
  assign unused_fields = ^bus.in_instr[19:15];

  // funct3 -> ALU op map shared by R and I types
  alu_op_e map_ctrl;
  logic    map_ok;
  logic    map_shift;

  always_comb begin
    map_ctrl  = ALU_ADD;
    map_ok    = 1'b1;
    map_shift = 1'b0;
    case (funct3)
      3'b000:  map_ctrl = ALU_ADD;
      3'b001:  begin map_ctrl = ALU_SLL; map_shift = 1'b1; end
      3'b011:  map_ctrl = ALU_SLTU;
      3'b100:  map_ctrl = ALU_XOR;
      3'b101:  begin map_ctrl = ALU_SRL; map_shift = 1'b1; end
      3'b110:  map_ctrl = ALU_OR;
      3'b111:  map_ctrl = ALU_AND;
      default: map_ok = 1'b0;
    endcase
  end

  alu_op_e         d_ctrl;
  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic            d_illegal;
  logic            d_branch;
  logic            d_bne;
  logic            d_wb;

  // Illegal instructions fall through with ADD and zero operands.
  always_comb begin
    d_ctrl    = ALU_ADD;
    d_a       = '0;
    d_b       = '0;
    d_illegal = 1'b1;
    d_branch  = 1'b0;
    d_bne     = 1'b0;
    d_wb      = 1'b0;
    case (opcode)
      OP_R: begin
        if (map_ok && (funct7 == 7'b0000000 ||
                       (funct3 == 3'b000 && funct7 == 7'b0100000))) begin
          d_illegal = 1'b0;
          d_ctrl    = funct7[5] ? ALU_SUB : map_ctrl;
          d_a       = bus.in_rs1_val;
          d_b       = map_shift ? {{(XLEN-5){1'b0}}, bus.in_rs2_val[4:0]} : bus.in_rs2_val;
          d_wb      = (rd != 5'd0);
        end
      end
      OP_I: begin
        if (map_ok && (!map_shift || funct7 == 7'b0000000)) begin
          d_illegal = 1'b0;
          d_ctrl    = map_ctrl;
          d_a       = bus.in_rs1_val;
          d_b       = map_shift ? {{(XLEN-5){1'b0}}, bus.in_instr[24:20]}
                                : {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
          d_wb      = (rd != 5'd0);
        end
      end
      OP_B: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          d_illegal = 1'b0;
          d_ctrl    = ALU_SUB;
          d_a       = bus.in_rs1_val;
          d_b       = bus.in_rs2_val;
          d_branch  = 1'b1;
          d_bne     = funct3[0];
        end
      end
      default: ;
    endcase
  end

  logic       s1_v;
  alu_op_e    s1_ctrl;
  logic [4:0] s1_rd;
  logic       s1_illegal;
  logic       s1_branch;
  logic       s1_bne;
  logic       s1_wb;
  logic       s2_load;
  logic       accept;
  logic       out_fire;

  assign s2_load      = s1_v & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = ~s1_v | s2_load;
  assign accept       = bus.in_valid & bus.in_ready & ~flush;
  assign out_fire     = bus.out_valid & bus.out_ready & ~flush;
  assign bus.alu_ctrl = s1_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v         <= 1'b0;
      s1_ctrl      <= ALU_ADD;
      s1_rd        <= '0;
      s1_illegal   <= 1'b0;
      s1_branch    <= 1'b0;
      s1_bne       <= 1'b0;
      s1_wb        <= 1'b0;
      bus.alu_op_a <= '0;
      bus.alu_op_b <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
    end else if (accept) begin
      s1_v         <= 1'b1;
      s1_ctrl      <= d_ctrl;
      s1_rd        <= rd;
      s1_illegal   <= d_illegal;
      s1_branch    <= d_branch;
      s1_bne       <= d_bne;
      s1_wb        <= d_wb;
      bus.alu_op_a <= d_a;
      bus.alu_op_b <= d_b;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_rd      <= '0;
      bus.out_result  <= '0;
      bus.out_wb_en   <= 1'b0;
      bus.out_branch  <= 1'b0;
      bus.out_taken   <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid   <= 1'b1;
      bus.out_rd      <= s1_rd;
      bus.out_result  <= (s1_illegal | s1_branch) ? '0 : bus.alu_result;
      bus.out_wb_en   <= s1_wb;
      bus.out_branch  <= s1_branch;
      bus.out_taken   <= s1_branch & (bus.alu_zero ^ s1_bne);
      bus.out_illegal <= s1_illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (out_fire) begin
      if (issued_cnt != '1)
        issued_cnt <= issued_cnt + 1'b1;
      if (bus.out_illegal && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the operand/result wires;
// counters are 4 bits wide here so saturation is reachable quickly.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] issued_cnt;
  logic [3:0] illegal_cnt;
  int         passed = 0;
  int         total  = 0;
  int         failed = 0;

  alu_issue_ctrl_if #(.XLEN(32)) bus ();

  alu_issue_ctrl #(.XLEN(32), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .issued_cnt  (issued_cnt),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      3'b000: alu_res = bus.alu_op_a + bus.alu_op_b;
      3'b001: alu_res = bus.alu_op_a - bus.alu_op_b;
      3'b010: alu_res = bus.alu_op_a & bus.alu_op_b;
      3'b011: alu_res = bus.alu_op_a | bus.alu_op_b;
      3'b100: alu_res = bus.alu_op_a ^ bus.alu_op_b;
      3'b101: alu_res = bus.alu_op_a << bus.alu_op_b[4:0];
      3'b110: alu_res = bus.alu_op_a >> bus.alu_op_b[4:0];
      default: alu_res = {31'd0, bus.alu_op_a < bus.alu_op_b};
    endcase
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_zero   = (alu_res == 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid   = 1'b1;
    bus.in_instr   = ins;
    bus.in_rs1_val = a;
    bus.in_rs2_val = b;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] b_instr [8];
  logic [31:0] b_a     [8];
  logic [31:0] b_b     [8];
  logic [31:0] b_res   [8];
  logic [4:0]  b_rd    [8];
  int          idx_in;
  int          idx_out;
  logic        fin;
  logic        fout;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_rs1_val = '0;
    bus.in_rs2_val = '0;
    bus.out_ready  = 1'b1;
    #12;
    check("rst_in_ready",   32'(bus.in_ready),  32'd1);
    check("rst_out_valid",  32'(bus.out_valid), 32'd0);
    check("rst_alu_ctrl",   32'(bus.alu_ctrl),  32'd0);
    check("rst_op_a",       bus.alu_op_a,       32'd0);
    check("rst_op_b",       bus.alu_op_b,       32'd0);
    check("rst_out_result", bus.out_result,     32'd0);
    check("rst_issued",     32'(issued_cnt),    32'd0);
    rst_n = 1'b1;
    tick();

    // add x3,x1,x2
    issue(32'h002081B3, 32'd5, 32'd7);
    check("add_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("add_op_a", bus.alu_op_a, 32'd5);
    check("add_op_b", bus.alu_op_b, 32'd7);
    tick();
    check("add_valid",   32'(bus.out_valid),   32'd1);
    check("add_result",  bus.out_result,       32'd12);
    check("add_rd",      32'(bus.out_rd),      32'd3);
    check("add_wb",      32'(bus.out_wb_en),   32'd1);
    check("add_illegal", 32'(bus.out_illegal), 32'd0);

    // sub x4,x1,x2
    issue(32'h40208233, 32'h1234, 32'h1234);
    check("sub_ctrl", 32'(bus.alu_ctrl), 32'd1);
    tick();
    check("sub_result", bus.out_result,     32'd0);
    check("sub_rd",     32'(bus.out_rd),    32'd4);
    check("sub_wb",     32'(bus.out_wb_en), 32'd1);

    // beq x1,x2 equal
    issue(32'h00208063, 32'h55, 32'h55);
    check("beq_ctrl", 32'(bus.alu_ctrl), 32'd1);
    tick();
    check("beq_branch", 32'(bus.out_branch), 32'd1);
    check("beq_taken",  32'(bus.out_taken),  32'd1);
    check("beq_wb",     32'(bus.out_wb_en),  32'd0);
    check("beq_result", bus.out_result,      32'd0);

    // bne x1,x2 equal, then unequal
    issue(32'h00209063, 32'h55, 32'h55);
    tick();
    check("bne_eq_branch", 32'(bus.out_branch), 32'd1);
    check("bne_eq_taken",  32'(bus.out_taken),  32'd0);
    issue(32'h00209063, 32'h55, 32'h56);
    tick();
    check("bne_ne_taken",  32'(bus.out_taken),  32'd1);

    // addi x0,x0,-1 : sign-extended immediate, no writeback to x0
    issue(32'hFFF00013, 32'd10, 32'd0);
    check("addi_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("addi_op_b", bus.alu_op_b, 32'hFFFF_FFFF);
    tick();
    check("addi_result",  bus.out_result,       32'd9);
    check("addi_wb",      32'(bus.out_wb_en),   32'd0);
    check("addi_illegal", 32'(bus.out_illegal), 32'd0);

    // slli x6,x1,4
    issue(32'h00409313, 32'd3, 32'd0);
    check("slli_ctrl", 32'(bus.alu_ctrl), 32'd5);
    check("slli_op_b", bus.alu_op_b, 32'd4);
    tick();
    check("slli_result", bus.out_result,  32'd48);
    check("slli_rd",     32'(bus.out_rd), 32'd6);

    // srai x5,x1,3 is not supported
    issue(32'h4030D293, 32'h80, 32'd0);
    check("srai_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("srai_op_a", bus.alu_op_a, 32'd0);
    check("srai_op_b", bus.alu_op_b, 32'd0);
    tick();
    check("srai_illegal", 32'(bus.out_illegal), 32'd1);
    check("srai_wb",      32'(bus.out_wb_en),   32'd0);
    check("srai_branch",  32'(bus.out_branch),  32'd0);
    check("srai_result",  bus.out_result,       32'd0);
    tick();
    check("cnt_issued_8",  32'(issued_cnt),  32'd8);
    check("cnt_illegal_1", 32'(illegal_cnt), 32'd1);

    // Fill both stages, then flush
    bus.out_ready = 1'b0;
    issue(32'h002081B3, 32'd1, 32'd2);
    issue(32'h002081B3, 32'd3, 32'd4);
    check("flush_pre_valid", 32'(bus.out_valid), 32'd1);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid_1",  32'(bus.out_valid), 32'd0);
    check("flush_issued_1", 32'(issued_cnt),    32'd8);
    tick();
    check("flush_valid_2",  32'(bus.out_valid), 32'd0);
    check("flush_issued_2", 32'(issued_cnt),    32'd8);

    // Burst of 8 with a 3-cycle output stall: alternating add / xor
    for (int i = 0; i < 8; i++) begin
      b_rd[i] = 5'(i + 1);
      b_a[i]  = 32'(i * 3 + 1);
      b_b[i]  = 32'(100 + i);
      if (i % 2 == 0) begin
        b_instr[i] = {7'b0000000, 5'd2, 5'd1, 3'b000, b_rd[i], 7'b0110011};
        b_res[i]   = b_a[i] + b_b[i];
      end else begin
        b_instr[i] = {7'b0000000, 5'd2, 5'd1, 3'b100, b_rd[i], 7'b0110011};
        b_res[i]   = b_a[i] ^ b_b[i];
      end
    end
    idx_in  = 0;
    idx_out = 0;
    for (int cyc = 0; cyc < 40 && idx_out < 8; cyc++) begin
      bus.in_valid = (idx_in < 8);
      if (idx_in < 8) begin
        bus.in_instr   = b_instr[idx_in];
        bus.in_rs1_val = b_a[idx_in];
        bus.in_rs2_val = b_b[idx_in];
      end
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      fin  = bus.in_valid & bus.in_ready;
      fout = bus.out_valid & bus.out_ready;
      if (fout) begin
        check($sformatf("burst_rd_%0d", idx_out),     32'(bus.out_rd), 32'(b_rd[idx_out]));
        check($sformatf("burst_result_%0d", idx_out), bus.out_result,  b_res[idx_out]);
      end
      tick();
      if (fin)  idx_in++;
      if (fout) idx_out++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("burst_count",  32'(idx_out),     32'd8);
    check("burst_issued", 32'(issued_cnt),  32'd15);
    check("burst_illegal", 32'(illegal_cnt), 32'd1);

    // Saturated counter holds
    issue(32'h002081B3, 32'd5, 32'd7);
    tick();
    tick();
    check("sat_issued", 32'(issued_cnt), 32'd15);

    // Asynchronous reset with S1 occupied
    issue(32'h002081B3, 32'd5, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_op_a",    bus.alu_op_a,       32'd0);
    check("arst_result",  bus.out_result,     32'd0);
    check("arst_valid",   32'(bus.out_valid), 32'd0);
    check("arst_issued",  32'(issued_cnt),    32'd0);
    check("arst_illegal", 32'(illegal_cnt),   32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_no_output", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
